id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus load-use hazard detection for the 5-stage RISC-V pipeline.
- Captures decoded instructions from ID and presents register indices (ex_rs1, ex_rs2, ex_rd) and operands to EX, where the forwarding unit and ALU operand muxes consume them.
- Generates the front-end stall, inserts bubbles, honours branch flushes and downstream back-pressure.
- Snoops the WB write port so that captured or held operands are never stale.

Parameters:
- XLEN, 32, datapath/operand/PC width
- CNT_W, 16, width of the saturating load-use bubble counter

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a valid instruction
- id_pc  input  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  input  5 each  register indices
- id_uses_rs1, id_uses_rs2  input  1 each  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  input  XLEN each  register-file read data
- id_imm  input  XLEN  immediate
- id_alu_op  input  4  ALU operation
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  input  1 each  control bits
- flush_ex  input  1  branch/jump mispredict resolved; kill instruction entering EX
- ex_ready  input  1  EX can accept; 0 = multi-cycle EX op in progress
- wb_reg_write  input  1  WB writes register file this cycle
- wb_rd  input  5  WB destination
- wb_data  input  XLEN  WB write data
- ex_valid  output  1  EX holds a valid instruction
- ex_pc, ex_imm  output  XLEN each
- ex_rs1, ex_rs2, ex_rd  output  5 each  to forwarding unit / EX/MEM
- ex_rs1_data, ex_rs2_data  output  XLEN each
- ex_alu_op  output  4
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  output  1 each
- stall_id  output  1  hold PC and IF/ID register
- bubble_cnt  output  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset: every registered output cleared to 0, including ex_valid, all control bits, indices, data, pc, imm and bubble_cnt.
- load_use (combinational) = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- stall_id (combinational) = !flush_ex & (!ex_ready | load_use).
- Per-edge update, priority order:
  1. reset.
  2. flush_ex=1 → bubble; overrides ex_ready=0. bubble_cnt is not incremented.
  3. ex_ready=0 → hold all fields; apply WB snoop.
  4. load_use=1 → bubble; bubble_cnt += 1, saturating at 2^CNT_W-1.
  5. Otherwise capture ID. A capture with id_valid=0 is a bubble.
- Bubble definition: ex_valid=0; ex_reg_write, ex_mem_read, ex_mem_write, ex_branch = 0; ex_rs1, ex_rs2, ex_rd = 0, so forwarding comparisons cannot match. Remaining fields are also cleared to 0.
- Capture bypass: if wb_reg_write & wb_rd != 0 & wb_rd == id_rs1, then ex_rs1_data <= wb_data, else id_rs1_data. rs2 is handled the same way. Both can match in the same cycle.
- Hold snoop: while holding with ex_valid=1, if wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1, then ex_rs1_data <= wb_data. rs2 is handled the same way. No snoop on bubbles.
- x0: writes with wb_rd=0 are never bypassed or snooped; ex_rd=0 never triggers load_use.
- Latency: one cycle ID→EX. A load-use hazard costs exactly one bubble; the condition clears once the load moves to MEM.
- Simultaneous load_use & !ex_ready: hold wins, no bubble and no count. The hazard is re-evaluated once ex_ready returns.
- Reset mid-stall: the next cycle is clean. ex_valid=0, stall_id then depends only on current inputs, and bubble_cnt=0.

Test Plan:
- Reset then lw x5 in EX, ID add x6,x5,x7 (uses_rs1) → stall_id=1 for one cycle, ex_valid=0 next cycle, bubble_cnt=1; add enters EX the following cycle.
- lw x0 in EX, ID reads x0 → no stall, no bubble; load x5 with ID using x5 only as an unused rs2 (id_uses_rs2=0) → no stall.
- ex_ready=0 for 3 cycles with ex_rs1=x3 while WB writes x3=0xDEADBEEF → all fields held, stall_id=1 throughout, ex_rs1_data=0xDEADBEEF after the snoop cycle.
- flush_ex=1 together with load_use=1 and ex_ready=0 → stall_id=0, next-cycle ex_valid=0, ex_rd=0, ex_reg_write=0, bubble_cnt unchanged.
- Capture with wb_rd=id_rs1=id_rs2=x9, wb_data=0x1234 → ex_rs1_data=ex_rs2_data=0x1234 regardless of id_rs*_data.
- CNT_W=2: five load-use bubbles → bubble_cnt saturates at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/back-pressure handling and WB bypass/snoop of the captured operands.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_branch,
  input  logic             flush_ex,
  input  logic             ex_ready,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic             stall_id,
  output logic [CNT_W-1:0] bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             vld_p1;
  logic [XLEN-1:0]  pc_p1, imm_p1, rs1_data_p1, rs2_data_p1;
  logic [4:0]       rs1_p1, rs2_p1, rd_p1;
  logic [3:0]       alu_op_p1;
  logic             alu_src_p1, mem_read_p1, mem_write_p1;
  logic             reg_write_p1, mem_to_reg_p1, branch_p1;
  logic [CNT_W-1:0] bubble_cnt_p1;

  logic load_use, wb_ok, bubble, capture;
  logic id_hit1, id_hit2, ex_hit1, ex_hit2;

  assign load_use = vld_p1 && mem_read_p1 && (rd_p1 != 5'd0) && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == rd_p1)) ||
                     (id_uses_rs2 && (id_rs2 == rd_p1)));
  assign stall_id = !flush_ex && (!ex_ready || load_use);

  assign wb_ok   = wb_reg_write && (wb_rd != 5'd0);
  assign id_hit1 = wb_ok && (wb_rd == id_rs1);
  assign id_hit2 = wb_ok && (wb_rd == id_rs2);
  assign ex_hit1 = wb_ok && vld_p1 && (wb_rd == rs1_p1);
  assign ex_hit2 = wb_ok && vld_p1 && (wb_rd == rs2_p1);

  // A held stage (ex_ready=0) is neither a bubble nor a capture.
  assign bubble  = flush_ex || (ex_ready && (load_use || !id_valid));
  assign capture = !flush_ex && ex_ready && !load_use && id_valid;

  // ID -> EX stage boundary
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      vld_p1        <= 1'b0;
      pc_p1         <= '0;
      imm_p1        <= '0;
      rs1_p1        <= '0;
      rs2_p1        <= '0;
      rd_p1         <= '0;
      rs1_data_p1   <= '0;
      rs2_data_p1   <= '0;
      alu_op_p1     <= '0;
      alu_src_p1    <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      branch_p1     <= 1'b0;
    end else if (capture) begin
      vld_p1        <= 1'b1;
      pc_p1         <= id_pc;
      imm_p1        <= id_imm;
      rs1_p1        <= id_rs1;
      rs2_p1        <= id_rs2;
      rd_p1         <= id_rd;
      rs1_data_p1   <= id_hit1 ? wb_data : id_rs1_data;
      rs2_data_p1   <= id_hit2 ? wb_data : id_rs2_data;
      alu_op_p1     <= id_alu_op;
      alu_src_p1    <= id_alu_src;
      mem_read_p1   <= id_mem_read;
      mem_write_p1  <= id_mem_write;
      reg_write_p1  <= id_reg_write;
      mem_to_reg_p1 <= id_mem_to_reg;
      branch_p1     <= id_branch;
    end else begin
      if (ex_hit1) rs1_data_p1 <= wb_data;
      if (ex_hit2) rs2_data_p1 <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt_p1 <= '0;
    else if (!flush_ex && ex_ready && load_use)
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
  end

  assign ex_valid      = vld_p1;
  assign ex_pc         = pc_p1;
  assign ex_imm        = imm_p1;
  assign ex_rs1        = rs1_p1;
  assign ex_rs2        = rs2_p1;
  assign ex_rd         = rd_p1;
  assign ex_rs1_data   = rs1_data_p1;
  assign ex_rs2_data   = rs2_data_p1;
  assign ex_alu_op     = alu_op_p1;
  assign ex_alu_src    = alu_src_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_to_reg = mem_to_reg_p1;
  assign ex_branch     = branch_p1;
  assign bubble_cnt    = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/snoop scenarios plus random
// traffic against an instruction-level model; a CNT_W=2 copy covers saturation.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, id_valid, id_uses_rs1, id_uses_rs2;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0]      id_rs1, id_rs2, id_rd, wb_rd;
  logic [3:0]      id_alu_op;
  logic [5:0]      id_ctl; // {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}
  logic            flush_ex, ex_ready, wb_reg_write;

  logic            ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, stall_id;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_alu_op;
  logic [15:0]     bubble_cnt;

  logic            s_valid, s_alu_src, s_mem_read, s_mem_write, s_reg_write, s_mem_to_reg, s_branch, s_stall;
  logic [XLEN-1:0] s_pc, s_imm, s_rs1_data, s_rs2_data;
  logic [4:0]      s_rs1, s_rs2, s_rd;
  logic [3:0]      s_alu_op;
  logic [1:0]      s_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_ctl[5]), .id_mem_read(id_ctl[4]),
    .id_mem_write(id_ctl[3]), .id_reg_write(id_ctl[2]), .id_mem_to_reg(id_ctl[1]),
    .id_branch(id_ctl[0]), .flush_ex(flush_ex), .ex_ready(ex_ready),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_ctl[5]), .id_mem_read(id_ctl[4]),
    .id_mem_write(id_ctl[3]), .id_reg_write(id_ctl[2]), .id_mem_to_reg(id_ctl[1]),
    .id_branch(id_ctl[0]), .flush_ex(flush_ex), .ex_ready(ex_ready),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
    .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_alu_op(s_alu_op),
    .ex_alu_src(s_alu_src), .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
    .ex_reg_write(s_reg_write), .ex_mem_to_reg(s_mem_to_reg), .ex_branch(s_branch),
    .stall_id(s_stall), .bubble_cnt(s_cnt)
  );

  wire [153:0] dut_vec = {ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
                          ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch};
  wire [153:0] sat_vec = {s_valid, s_pc, s_imm, s_rs1, s_rs2, s_rd, s_rs1_data, s_rs2_data,
                          s_alu_op, s_alu_src, s_mem_read, s_mem_write, s_reg_write, s_mem_to_reg, s_branch};

  // Model: the instruction currently sitting in EX, and the total bubbles inserted.
  logic            m_valid;
  logic [XLEN-1:0] m_pc, m_imm, m_d1, m_d2;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [3:0]      m_op;
  logic [5:0]      m_ctl;
  int              n_bub;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [5:0] CTL_LW  = 6'b110110;
  localparam logic [5:0] CTL_ALU = 6'b000100;

  function automatic logic [153:0] mvec();
    return {m_valid, m_pc, m_imm, m_rs1, m_rs2, m_rd, m_d1, m_d2, m_op, m_ctl};
  endfunction

  function automatic int exp_cnt16();
    return (n_bub > 65535) ? 65535 : n_bub;
  endfunction

  function automatic int exp_cnt2();
    return (n_bub > 3) ? 3 : n_bub;
  endfunction

  function automatic logic m_load_use();
    // A load in EX whose destination the ID instruction genuinely reads.
    return m_valid && m_ctl[4] && (m_rd != 0) && id_valid &&
           ((id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd));
  endfunction

  function automatic logic m_stall();
    return !flush_ex && (!ex_ready || m_load_use());
  endfunction

  task automatic m_clear();
    m_valid = 0; m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_ctl = 0;
  endtask

  // Advance the model by what the EX slot should hold after this edge, then clock.
  task automatic tick();
    logic lu;
    logic wb_live;
    lu = m_load_use();
    wb_live = wb_reg_write && (wb_rd != 0);
    if (reset) begin
      m_clear(); n_bub = 0;
    end else if (flush_ex) begin
      m_clear();
    end else if (!ex_ready) begin
      if (m_valid && wb_live && wb_rd == m_rs1) m_d1 = wb_data;
      if (m_valid && wb_live && wb_rd == m_rs2) m_d2 = wb_data;
    end else if (lu) begin
      m_clear(); n_bub++;
    end else if (!id_valid) begin
      m_clear();
    end else begin
      m_valid = 1; m_pc = id_pc; m_imm = id_imm; m_op = id_alu_op; m_ctl = id_ctl;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = (wb_live && wb_rd == id_rs1) ? wb_data : id_rs1_data;
      m_d2 = (wb_live && wb_rd == id_rs2) ? wb_data : id_rs2_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; flush_ex = 0; ex_ready = 1; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_ctl = 0; id_alu_op = 0; id_pc = 0; id_imm = 0; id_rs1_data = 0; id_rs2_data = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic [5:0] ctl);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctl = ctl;
    id_pc = $urandom; id_imm = $urandom; id_alu_op = 4'($urandom);
    id_rs1_data = $urandom; id_rs2_data = $urandom;
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    tick(); tick();
    reset = 0;
    n_chk++;
    if (dut_vec !== '0 || bubble_cnt !== 0) begin
      n_fail++; $display("FAIL reset_state: got %h cnt %0d, want all zero", dut_vec, bubble_cnt);
    end
  endtask

  task automatic test_load_use();
    set_id(5'd1, 5'd2, 5'd5, 1, 0, CTL_LW); #1;
    n_chk++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_pre_stall: got %b want 0", stall_id); end
    tick();
    set_id(5'd5, 5'd7, 5'd6, 1, 1, CTL_ALU); #1;
    n_chk++;
    if (stall_id !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall_id); end
    tick();
    n_chk++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || bubble_cnt !== 16'd1) begin
      n_fail++; $display("FAIL lu_bubble: valid %b rd %0d cnt %0d, want 0 0 1", ex_valid, ex_rd, bubble_cnt);
    end
    n_chk++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_release: stall %b want 0", stall_id); end
    tick();
    n_chk++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rs1 !== 5'd5 || dut_vec !== mvec()) begin
      n_fail++; $display("FAIL lu_enter: got %h want %h", dut_vec, mvec());
    end
    idle();
  endtask

  task automatic test_x0();
    set_id(5'd1, 5'd2, 5'd0, 0, 0, CTL_LW); tick();
    set_id(5'd0, 5'd0, 5'd3, 1, 1, CTL_ALU); #1;
    n_chk++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", stall_id); end
    tick();
    n_chk++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd3) begin
      n_fail++; $display("FAIL x0_enter: valid %b rd %0d want 1 3", ex_valid, ex_rd);
    end
    set_id(5'd1, 5'd1, 5'd5, 0, 0, CTL_LW); tick();
    set_id(5'd1, 5'd5, 5'd4, 1, 0, CTL_ALU); #1;
    n_chk++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL unused_rs2_stall: got %b want 0", stall_id); end
    tick();
    idle();
  endtask

  task automatic test_hold_snoop();
    set_id(5'd3, 5'd4, 5'd8, 1, 1, CTL_ALU);
    id_pc = 32'h100; id_rs1_data = 32'h11; id_rs2_data = 32'h22;
    tick();
    set_id(5'd9, 5'd10, 5'd11, 1, 1, CTL_ALU);
    ex_ready = 0; wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (stall_id !== 1'b1) begin n_fail++; $display("FAIL hold_stall[%0d]: got %b want 1", i, stall_id); end
      tick();
      wb_reg_write = 0;
      n_chk++;
      if (ex_pc !== 32'h100 || ex_rd !== 5'd8 || ex_rs1_data !== 32'hDEADBEEF || ex_rs2_data !== 32'h22) begin
        n_fail++; $display("FAIL hold_snoop[%0d]: pc %h rd %0d d1 %h d2 %h, want 100 8 deadbeef 22",
                           i, ex_pc, ex_rd, ex_rs1_data, ex_rs2_data);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    int c;
    set_id(5'd1, 5'd2, 5'd5, 0, 0, CTL_LW); tick();
    set_id(5'd5, 5'd6, 5'd7, 1, 1, CTL_ALU);
    ex_ready = 0; flush_ex = 1; #1;
    c = bubble_cnt;
    n_chk++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall_id); end
    tick();
    n_chk++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0 || bubble_cnt !== 16'(c)) begin
      n_fail++; $display("FAIL flush_bubble: valid %b rd %0d rw %b cnt %0d, want 0 0 0 %0d",
                         ex_valid, ex_rd, ex_reg_write, bubble_cnt, c);
    end
    idle();
  endtask

  task automatic test_bypass();
    set_id(5'd9, 5'd9, 5'd12, 1, 1, CTL_ALU);
    wb_reg_write = 1; wb_rd = 5'd9; wb_data = 32'h1234;
    tick();
    n_chk++;
    if (ex_rs1_data !== 32'h1234 || ex_rs2_data !== 32'h1234) begin
      n_fail++; $display("FAIL capture_bypass: d1 %h d2 %h want 1234 1234", ex_rs1_data, ex_rs2_data);
    end
    set_id(5'd0, 5'd0, 5'd12, 1, 1, CTL_ALU);
    wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'h5555;
    tick();
    n_chk++;
    if (ex_rs1_data !== m_d1 || ex_rs1_data === 32'h5555) begin
      n_fail++; $display("FAIL x0_no_bypass: d1 %h want %h", ex_rs1_data, m_d1);
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    set_id(5'd1, 5'd2, 5'd5, 0, 0, CTL_LW); tick();
    set_id(5'd5, 5'd2, 5'd6, 1, 0, CTL_ALU); ex_ready = 0; reset = 1;
    tick();
    reset = 0; ex_ready = 1; #1;
    n_chk++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 16'd0 || stall_id !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_stall: valid %b cnt %0d stall %b, want 0 0 0", ex_valid, bubble_cnt, stall_id);
    end
    idle();
  endtask

  task automatic test_saturate();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 5; i++) begin
      set_id(5'd1, 5'd2, 5'd5, 0, 0, CTL_LW); tick();
      set_id(5'd5, 5'd2, 5'd6, 1, 0, CTL_ALU); tick();
    end
    n_chk++;
    if (s_cnt !== 2'd3 || bubble_cnt !== 16'd5) begin
      n_fail++; $display("FAIL saturate: cnt2 %0d cnt16 %0d, want 3 5", s_cnt, bubble_cnt);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush_ex = ($urandom_range(0, 11) == 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      set_id(5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
             1'($urandom), 1'($urandom), 6'($urandom));
      id_valid = ($urandom_range(0, 7) != 0);
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 4)); wb_data = $urandom;
      #1;
      n_chk++;
      if (stall_id !== m_stall() || s_stall !== m_stall()) begin
        n_fail++; $display("FAIL rnd_stall[%0d]: got %b/%b want %b", i, stall_id, s_stall, m_stall());
      end
      tick();
      n_chk++;
      if (dut_vec !== mvec() || sat_vec !== mvec()) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got %h want %h", i, dut_vec, mvec());
      end
      n_chk++;
      if (bubble_cnt !== 16'(exp_cnt16()) || s_cnt !== 2'(exp_cnt2())) begin
        n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bubble_cnt, s_cnt, exp_cnt16(), exp_cnt2());
      end
    end
    idle();
  endtask

  initial begin
    m_clear(); n_bub = 0;
    test_reset();
    test_load_use();
    test_x0();
    test_hold_snoop();
    test_flush();
    test_bypass();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
